// File: rtl/router_pkg.sv
// Shared types and defaults for the router output-port FIFO.
package router_pkg;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_LEN_LSB = 2;

    // One FIFO entry: header-marker tag above the stored byte.
    typedef struct packed {
        logic                  tag;
        logic [DEF_DATA_W-1:0] data;
    } fifo_word_t;

    // Payload length field of a header byte.
    function automatic logic [DEF_DATA_W-DEF_LEN_LSB-1:0] hdr_len(input logic [DEF_DATA_W-1:0] b);
        return b[DEF_DATA_W-1:DEF_LEN_LSB];
    endfunction

endpackage

// File: rtl/router_pkt_counter.sv
// Tracks packet boundaries on the read side and pulses pkt_done on the last byte.
module router_pkt_counter
    import router_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned LEN_LSB = DEF_LEN_LSB
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              rd_fire,
    input  logic              rd_tag,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pkt_done
);

    localparam int unsigned CW = DATA_W - LEN_LSB + 1;

    logic [CW-1:0] r_pkt_cnt;
    logic [CW-1:0] w_pkt_cnt_nxt;
    logic          r_pkt_done;
    logic          w_pkt_done_nxt;
    logic [CW-2:0] w_len;

    assign w_len    = rd_data[DATA_W-1:LEN_LSB];
    assign pkt_done = r_pkt_done;

    // Header reloads (payload + parity); body bytes count down; done on 1 -> 0.
    always_comb begin
        w_pkt_cnt_nxt  = r_pkt_cnt;
        w_pkt_done_nxt = 1'b0;
        if (soft_reset) begin
            w_pkt_cnt_nxt = '0;
        end else if (rd_fire) begin
            if (rd_tag) begin
                w_pkt_cnt_nxt = {1'b0, w_len} + CW'(1);
            end else if (r_pkt_cnt != '0) begin
                w_pkt_cnt_nxt  = r_pkt_cnt - CW'(1);
                w_pkt_done_nxt = (r_pkt_cnt == CW'(1));
            end
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pkt_cnt  <= '0;
            r_pkt_done <= 1'b0;
        end else begin
            r_pkt_cnt  <= w_pkt_cnt_nxt;
            r_pkt_done <= w_pkt_done_nxt;
        end
    end

endmodule

// File: rtl/router_fifo_pkt.sv
// Packet-aware per-port output FIFO: {tag,data} storage, occupancy flags, sticky overflow.
module router_fifo_pkt
    import router_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AFULL_TH = DEPTH - 2,
    parameter int unsigned LEN_LSB  = DEF_LEN_LSB
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic                     read_enb,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     ifd_state,
    output logic [DATA_W-1:0]        data_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pkt_done,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W:0]   r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_nxt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_empty;
    logic              r_full;
    logic              r_afull;
    logic              r_overflow;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic [DATA_W:0]   w_rd_word;

    assign w_wr_fire = write_enb && !r_full;
    assign w_rd_fire = read_enb && !r_empty;
    assign w_rd_word = r_mem[r_rptr];

    assign data_out    = r_data_out;
    assign empty       = r_empty;
    assign full        = r_full;
    assign almost_full = r_afull;
    assign count       = r_count;
    assign overflow    = r_overflow;

    // Net occupancy after this edge's accepted read/write; flush forces zero.
    always_comb begin
        w_count_nxt = r_count;
        if (soft_reset) begin
            w_count_nxt = '0;
        end else begin
            case ({w_wr_fire, w_rd_fire})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clock) begin
        if (w_wr_fire && !soft_reset) begin
            r_mem[r_wptr] <= {ifd_state, data_in};
        end
    end

    // Pointers, registered read data, occupancy and flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_afull <= (w_count_nxt >= CW'(AFULL_TH));
            if (soft_reset) begin
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_data_out <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_wr_fire) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_rd_fire) begin
                    r_rptr     <= r_rptr + AW'(1);
                    r_data_out <= w_rd_word[DATA_W-1:0];
                end
                if (write_enb && r_full) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    router_pkt_counter #(
        .DATA_W  (DATA_W),
        .LEN_LSB (LEN_LSB)
    ) u_pkt_counter (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .rd_fire    (w_rd_fire),
        .rd_tag     (w_rd_word[DATA_W]),
        .rd_data    (w_rd_word[DATA_W-1:0]),
        .pkt_done   (pkt_done)
    );

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Scoreboard bench for router_fifo_pkt with a small behavioural reference model.
module tb_router_fifo_pkt;
    import router_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 5;
    localparam int unsigned AFULL = DEPTH - 2;

    logic          clock;
    logic          reset;
    logic          soft_reset;
    logic          write_enb;
    logic          read_enb;
    logic [DW-1:0] data_in;
    logic          ifd_state;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [CW-1:0] count;
    logic          pkt_done;
    logic          overflow;

    int n_tests;
    int n_fail;

    fifo_word_t sb_q[$];
    int         m_count;
    int         m_pc;
    logic       m_ovf;
    logic       m_done;
    logic [7:0] m_dout;

    router_fifo_pkt #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL),
        .LEN_LSB  (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .soft_reset  (soft_reset),
        .write_enb   (write_enb),
        .read_enb    (read_enb),
        .data_in     (data_in),
        .ifd_state   (ifd_state),
        .data_out    (data_out),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .pkt_done    (pkt_done),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_count = 0;
        m_pc    = 0;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
        m_dout  = 8'h00;
    endtask

    task automatic check_all();
        chk("data_out",    32'(data_out),    32'(m_dout));
        chk("count",       32'(count),       32'(m_count));
        chk("empty",       32'(empty),       32'(m_count == 0));
        chk("full",        32'(full),        32'(m_count == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(m_count >= AFULL));
        chk("pkt_done",    32'(pkt_done),    32'(m_done));
        chk("overflow",    32'(overflow),    32'(m_ovf));
    endtask

    // Drive one cycle, advance the model, then compare after the edge.
    task automatic cycle(input logic we, input logic re, input logic [7:0] din,
                         input logic tag, input logic sr);
        fifo_word_t w;
        bit wa;
        bit ra;
        write_enb  = we;
        read_enb   = re;
        data_in    = din;
        ifd_state  = tag;
        soft_reset = sr;
        wa = we && (m_count < DEPTH);
        ra = re && (m_count > 0);
        m_done = 1'b0;
        if (sr) begin
            model_clear();
        end else begin
            if (we && m_count == DEPTH) m_ovf = 1'b1;
            if (ra) begin
                w = sb_q.pop_front();
                m_dout = w.data;
                if (w.tag) begin
                    m_pc = int'(hdr_len(w.data)) + 1;
                end else if (m_pc > 0) begin
                    m_done = (m_pc == 1);
                    m_pc--;
                end
            end
            if (wa) begin
                w.tag  = tag;
                w.data = din;
                sb_q.push_back(w);
            end
            m_count = m_count + int'(wa) - int'(ra);
        end
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] d, input logic tag);
        cycle(1'b1, 1'b0, d, tag, 1'b0);
    endtask

    task automatic rd();
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        data_in    = '0;
        ifd_state  = 1'b0;
        model_clear();

        // Reset
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_all();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);

        // Fill, overflow and wrap, with an initial pointer offset
        for (int k = 0; k < 3; k++) wr(8'($urandom_range(0, 255)), 1'b0);
        for (int k = 0; k < 3; k++) rd();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 16; i++) wr(8'($urandom_range(0, 255)), 1'b0);
            chk("pass_full", 32'(full), 32'd1);
            chk("pass_count", 32'(count), 32'd16);
            wr(8'hA5, 1'b0);
            chk("pass_ovf", 32'(overflow), 32'd1);
            for (int i = 0; i < 16; i++) rd();
            chk("pass_empty", 32'(empty), 32'd1);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("sr_ovf_clear", 32'(overflow), 32'd0);

        // Packet with length 3: done only with the parity byte
        wr(8'h0D, 1'b1);
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b0);
        wr(8'h33, 1'b0);
        wr(8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) begin
            rd();
            chk("pkt_done_seq", 32'(pkt_done), 32'(i == 4));
        end
        chk("pkt_parity", 32'(data_out), 32'h5A);
        idle();
        chk("pkt_done_pulse", 32'(pkt_done), 32'd0);

        // Zero-length header: done on the parity read
        wr(8'h00, 1'b1);
        wr(8'h77, 1'b0);
        for (int i = 0; i < 2; i++) begin
            rd();
            chk("pkt0_done_seq", 32'(pkt_done), 32'(i == 1));
        end

        // Simultaneous read/write at count 5
        for (int i = 0; i < 5; i++) wr(8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        chk("rw_count", 32'(count), 32'd5);
        for (int i = 0; i < 5; i++) rd();

        // Both requests while empty: write only
        cycle(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("rw_empty_count", 32'(count), 32'd1);
        rd();
        chk("rw_empty_data", 32'(data_out), 32'h3C);

        // Both requests while full: read only
        for (int i = 0; i < 16; i++) wr(8'($urandom_range(0, 255)), 1'b0);
        cycle(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
        chk("rw_full_count", 32'(count), 32'd15);
        for (int i = 0; i < 15; i++) rd();

        // Almost-full threshold
        for (int i = 0; i < 14; i++) begin
            wr(8'($urandom_range(0, 255)), 1'b0);
            chk("afull_rise", 32'(almost_full), 32'(i == 13));
        end
        rd();
        chk("afull_fall", 32'(almost_full), 32'd0);
        chk("afull_count", 32'(count), 32'd13);
        for (int i = 0; i < 13; i++) rd();

        // Soft reset mid-packet with a concurrent write
        wr(8'h0D, 1'b1);
        wr(8'h44, 1'b0);
        wr(8'h55, 1'b0);
        wr(8'h66, 1'b0);
        wr(8'h88, 1'b0);
        rd();
        rd();
        cycle(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
        chk("sr_count", 32'(count), 32'd0);
        chk("sr_empty", 32'(empty), 32'd1);
        chk("sr_dout", 32'(data_out), 32'd0);
        chk("sr_pkt_done", 32'(pkt_done), 32'd0);
        rd();
        wr(8'h42, 1'b0);
        rd();
        chk("sr_after_data", 32'(data_out), 32'h42);
        chk("sr_after_done", 32'(pkt_done), 32'd0);

        // Asynchronous reset between edges
        wr(8'h0D, 1'b1);
        wr(8'h12, 1'b0);
        wr(8'h34, 1'b0);
        write_enb = 1'b0;
        read_enb  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        chk("async_count", 32'(count), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        chk("async_dout", 32'(data_out), 32'd0);
        #2;
        reset = 1'b0;
        wr(8'h6B, 1'b0);
        rd();
        chk("async_resume", 32'(data_out), 32'h6B);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/router_fifo_pkt.md
# router_fifo_pkt

Parametrised, packet-aware successor to the router's per-port output FIFO. It buffers bytes from the router FSM toward one destination port and tags each entry with the header-marker bit (`ifd_state`). It decodes the header's payload length on read to track packet boundaries and signal packet completion. It adds configurable width and depth, occupancy and almost-full reporting, and a sticky overflow flag; soft reset flushes it.

## Interface
- `DATA_W`, 8: payload byte width; ≥ 4.
- `DEPTH`, 16: entries; power of two, ≥ 4.
- `AFULL_TH`, `DEPTH-2`: `almost_full` threshold, in entries.
- `LEN_LSB`, 2: LSB of the length field in a header byte. The field spans [`DATA_W`-1:`LEN_LSB`].
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `soft_reset` in 1: synchronous flush; takes priority over all other inputs.
- `write_enb` in 1: write request.
- `read_enb` in 1: read request.
- `data_in` in `DATA_W`: byte to store.
- `ifd_state` in 1: the byte being written is a header; stored as tag bit.
- `data_out` out `DATA_W`: registered read data.
- `empty` out 1: count == 0.
- `full` out 1: count == `DEPTH`.
- `almost_full` out 1: count ≥ `AFULL_TH`.
- `count` out $clog2(`DEPTH`)+1: occupancy.
- `pkt_done` out 1: one-cycle pulse, last byte of a packet read.
- `overflow` out 1: sticky; a write was attempted while full.

## Operation
- Storage: `DEPTH` × (`DATA_W`+1) words, formed as {tag, data}. Write/read pointers are $clog2(`DEPTH`) bits and wrap naturally.
- Write accept: `write_enb` && !`full`. A write while full is dropped, the pointer is unchanged, and `overflow` sets.
- Read accept: `read_enb` && !`empty`. A read while empty is ignored and `data_out` holds.
- Simultaneous accepted read and write: both pointers advance and `count` is unchanged.
- When full, a read and write in the same cycle accept the read only.
- When empty, a read and write in the same cycle accept the write only.
- Packet counter (`pkt_cnt`, `DATA_W`-`LEN_LSB`+1 bits):
  - On an accepted read with tag=1: load header[`DATA_W`-1:`LEN_LSB`] + 1 (payload plus parity byte).
  - On an accepted read with tag=0 and `pkt_cnt` > 0: decrement.
  - `pkt_done` pulses on the read that brings `pkt_cnt` from 1 to 0.
- Header with length 0: counter loads 1, and the following parity read raises `pkt_done`.
- Header read while `pkt_cnt` ≠ 0 (truncated packet): reload from the new header. No `pkt_done` is issued for the truncated packet.
- Soft reset: pointers, `count`, `pkt_cnt`, `data_out`, and `overflow` all clear to 0. Any write/read in the same cycle is discarded. RAM contents are don't-care.
- Reset values (async `reset`): `data_out`=0, `empty`=1, `full`=0, `almost_full`=0 (`AFULL_TH`>0), `count`=0, `pkt_done`=0, `overflow`=0.

## Timing
- All outputs are registered and update on the rising edge after the qualifying input.
- Read latency is 1: `data_out` is valid the cycle after the `read_enb` edge and holds until the next accepted read or flush.
- Write-to-read: a byte written at edge N is readable by `read_enb` sampled at edge N+1. `empty` deasserts after edge N.
- `full`, `almost_full`, and `count` reflect the net effect of the same edge's accepted read and write.
- `pkt_done` asserts in the same cycle as the `data_out` carrying the final byte.
- `reset` asserted mid-packet clears everything immediately, without waiting for a clock edge; operation resumes on the first edge after deassertion.

## Structure
- Shared package `router_pkg`:
  - default `DATA_W`
  - `LEN_LSB`
  - typedef `fifo_word_t` = packed struct {tag, data}
  - function `hdr_len(byte)` extracting the length field
- Sub-module `router_pkt_counter`: load/decrement/`pkt_done` logic. Inputs are `rd_fire`, `rd_tag`, `rd_data`, and `soft_reset`.
- The top level holds the RAM, pointers, count, and flags.

## Test plan
- Reset: hold `reset`=1 for 3 cycles, then release → `empty`=1, `full`=0, `count`=0, `data_out`=0, `overflow`=0.
- Fill and wrap: write 16 random bytes, then a 17th → `full`=1, `count`=16, `overflow`=1, 17th byte absent. Read 16 → exact order. Repeat 3 passes to exercise wrap.
- Packet: write header 0x0D (tag=1, len 3), 3 payload bytes, 1 parity byte, then read 5 → `pkt_done` high only with the parity on `data_out`. Also header 0x00 → `pkt_done` on the 2nd read.
- Simultaneous read/write:
  - `count`=5, both requests for 10 cycles → `count` stays 5, FIFO order preserved.
  - When empty, both requests → write only.
  - When full, both requests → read only.
- Flags: `AFULL_TH`=14 → `almost_full` rises on the 14th write and falls when `count` drops to 13.
- Soft reset mid-packet: after header plus 1 payload read, pulse `soft_reset` together with `write_enb` → `count`=0, `empty`=1, `data_out`=0, `overflow`=0, write discarded, no `pkt_done`.
